mdu_issue_ctrl: RTL and testbench
=================================

# mdu_issue_ctrl

Issue and hazard controller for the pipelined CPU's multiply/divide unit. It decodes the E-stage HI/LO operation and drives the MDU's start, opcode, HI/LO write-enable and operand lines. It keeps a shadow latency counter that tracks the MDU's in-flight operation and generates the D-stage stall for any HI/LO-related instruction while that operation is pending. It also cross-checks the MDU's busy flag against its own state.

## Interface
- MUL_LAT, 5: multiply latency in cycles; must equal the MDU's multiply count.
- DIV_LAT, 10: divide latency in cycles; must equal the MDU's divide count.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- e_valid  in  1  E-stage instruction is real, not a bubble
- e_op  in  4  0 NONE, 1 MULTU, 2 MULT, 3 DIVU, 4 DIV, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as NONE
- e_rs, e_rt  in  32  forwarded E-stage operands
- d_is_md  in  1  D-stage instruction is any of ops 1–8
- mdu_busy  in  1  MDU busy flag
- mdu_start  out  1  pulse that starts an MDU operation
- mdu_op  out  3  MDU op code: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV
- mdu_hiwe, mdu_lowe  out  1  MTHI / MTLO strobes
- mdu_in1, mdu_in2  out  32  operands to the MDU
- stall  out  1  freeze F/D, insert bubble into E
- pending  out  1  state is not IDLE
- err  out  1  sticky protocol error

## Operation
- States:
  - IDLE, MUL, DIV.
  - cnt is 4 bits.
- Decode: combinational from e_valid && e_op.
- Operation dispatch:
  - Ops 1–4:
    - Assert mdu_start with mdu_op mapped as listed in the interface.
    - mdu_in1 = e_rs, mdu_in2 = e_rt.
    - Load cnt with MUL_LAT (ops 1–2) or DIV_LAT (ops 3–4).
    - Go to MUL or DIV.
  - MTHI / MTLO: assert mdu_hiwe / mdu_lowe with mdu_in1 = e_rs; mdu_start stays 0.
  - MFHI / MFLO: no MDU drive; the read path is outside this block.
- MUL / DIV: cnt decrements each cycle; at cnt==1 the next state is IDLE.
- Issue guard:
  - Any op 1–8 arriving in E while state is not IDLE is suppressed: mdu_start, mdu_hiwe and mdu_lowe are forced to 0.
  - The same event sets err.
  - This cannot happen in a correct pipeline.
- stall = d_is_md && (pending || mdu_start).
- Consistency check: err is also set whenever mdu_busy != pending, evaluated in every cycle except the cycle directly after reset.
- err clears only on reset.
- Outputs not in use are 0. Operands are 0 when no op drives them.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE, cnt is 0.
- Issue at cycle t:
  - mdu_start is high in t only.
  - pending is high in cycles t+1 .. t+L, where L is the selected latency.
  - HI/LO are written by the MDU at the end of t+L.
  - pending drops at that same edge.
- stall is high in cycles t .. t+L when d_is_md is set. The earliest dependent MFHI reaches E at t+L+1.
- Back-to-back MULT then MFLO: the MFLO holds in D for exactly L+1 cycles.
- MTHI / MTLO complete in one cycle and cause no stall.
- Reset in mid-operation returns to IDLE immediately. The MDU is reset by the same signal.

## Configuration
- MDU_DIVZERO_TRAP_EN
  - Defined:
    - DIVU or DIV with e_rt==0 does not issue: no start, state stays IDLE.
    - Output div_zero (1 bit) pulses for one cycle; HI/LO are unchanged.
    - The port div_zero exists only when the macro is defined.
  - Undefined: divide-by-zero issues normally; the block holds state for DIV_LAT cycles.

## Structure
- Shared package holds:
  - the e_op encodings;
  - the MDU op codes (must match the MDU's 000–011);
  - the state enum;
  - the default MUL_LAT / DIV_LAT constants.
- One sub-module, mdu_op_decode: combinational e_op to {is_mul, is_div, is_mt_hi, is_mt_lo, is_mf, signed}.

## Test plan
- MULT with e_rs=0xFFFFFFFE, e_rt=3, and d_is_md=1 held → mdu_start for 1 cycle with mdu_op=001; stall high for 6 cycles; pending for 5 cycles; err stays 0.
- DIVU 100/7 followed by MFHI in D → stall high for 11 cycles, then pending=0 and MFHI advances.
- MTLO with e_rs=0x1234 → mdu_lowe pulse, mdu_in1=0x1234, stall=0, pending=0.
- MULTU injected in E while pending (forced stimulus) → no mdu_start; err goes to 1 and stays 1 until reset.
- Reset asserted at cnt=4 of a DIV → the next cycle has pending=0, stall=0, err=0.
- DIV with e_rt=0:
  - with MDU_DIVZERO_TRAP_EN → div_zero pulse, no start;
  - without the macro → 10-cycle pending.

Source files
------------

// File: rtl/mdu_issue_ctrl_pkg.sv
// mdu_issue_ctrl_pkg
// Shared definitions for the MDU issue/hazard controller:
//   - E-stage HI/LO operation encodings (e_op)
//   - MDU opcode values driven on mdu_op; these match the MDU's 000-011 coding
//   - issue FSM state enum
//   - default multiply / divide latencies
package mdu_issue_ctrl_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_MULT  = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_issue_ctrl_op_decode.sv
// mdu_op_decode
// Combinational classification of the E-stage HI/LO operation.
// Ports:
//   valid      in   E-stage instruction is real
//   op[3:0]    in   e_op encoding (9-15 behave as NONE)
//   is_mul     out  MULTU / MULT
//   is_div     out  DIVU / DIV
//   is_mt_hi   out  MTHI
//   is_mt_lo   out  MTLO
//   is_mf      out  MFHI / MFLO
//   is_signed  out  MULT / DIV (signed flavour)
module mdu_op_decode
  import mdu_issue_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [3:0] op,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_mt_hi,
  output logic       is_mt_lo,
  output logic       is_mf,
  output logic       is_signed
);

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_mt_hi  = 1'b0;
    is_mt_lo  = 1'b0;
    is_mf     = 1'b0;
    is_signed = 1'b0;
    if (valid) begin
      case (op)
        OP_MULTU: is_mul = 1'b1;
        OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
        OP_DIVU:  is_div = 1'b1;
        OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
        OP_MFHI,
        OP_MFLO:  is_mf = 1'b1;
        OP_MTHI:  is_mt_hi = 1'b1;
        OP_MTLO:  is_mt_lo = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl
// Issue and hazard controller for the multiply/divide unit. Decodes the
// E-stage HI/LO op, drives the MDU start/opcode/HI-LO strobes/operands,
// shadows the MDU latency with a down-counter and stalls any D-stage HI/LO
// instruction while an MDU operation is in flight. Flags a sticky error on
// an issue while busy or when the MDU busy flag disagrees with the shadow.
// Optional feature macro: MDU_DIVZERO_TRAP_EN (divide by zero does not issue,
// div_zero pulses instead; the div_zero port exists only with the macro).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   e_valid, e_op         E-stage op and its valid
//   e_rs, e_rt            forwarded E-stage operands
//   d_is_md               D-stage instruction is any HI/LO op
//   mdu_busy              MDU busy flag (cross-checked)
//   mdu_start, mdu_op     MDU start pulse and opcode
//   mdu_hiwe, mdu_lowe    MTHI / MTLO strobes
//   mdu_in1, mdu_in2      MDU operands
//   div_zero              divide-by-zero trap pulse (macro only)
//   stall, pending, err   D-stage stall, op in flight, sticky error
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_is_md,
  input  logic        mdu_busy,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic        mdu_hiwe,
  output logic        mdu_lowe,
  output logic [31:0] mdu_in1,
  output logic [31:0] mdu_in2,
`ifdef MDU_DIVZERO_TRAP_EN
  output logic        div_zero,
`endif
  output logic        stall,
  output logic        pending,
  output logic        err
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       chk_skip;
  logic       guard_hit;
  logic       dz_trap;
  logic       is_mul, is_div, is_mt_hi, is_mt_lo, is_mf, is_signed;
  logic       is_md;

  mdu_op_decode u_decode (
    .valid     (e_valid),
    .op        (e_op),
    .is_mul    (is_mul),
    .is_div    (is_div),
    .is_mt_hi  (is_mt_hi),
    .is_mt_lo  (is_mt_lo),
    .is_mf     (is_mf),
    .is_signed (is_signed)
  );

  assign is_md = is_mul | is_div | is_mt_hi | is_mt_lo | is_mf;

`ifdef MDU_DIVZERO_TRAP_EN
  assign dz_trap = is_div && (e_rt == 32'd0);
`else
  assign dz_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      err      <= 1'b0;
      chk_skip <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      chk_skip <= 1'b0;
      // The first cycle out of reset is exempt: the MDU comes out of the
      // same reset and its busy flag may not have settled yet.
      if (guard_hit || (!chk_skip && (mdu_busy != pending)))
        err <= 1'b1;
    end
  end

  // Outputs are gated by reset so the whole interface reads 0 while the
  // pipeline is held in reset.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mdu_start  = 1'b0;
    mdu_op     = 3'b000;
    mdu_hiwe   = 1'b0;
    mdu_lowe   = 1'b0;
    mdu_in1    = 32'd0;
    mdu_in2    = 32'd0;
    guard_hit  = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if ((is_mul || is_div) && !dz_trap) begin
            mdu_start  = 1'b1;
            mdu_op     = {1'b0, is_div, is_signed};
            mdu_in1    = e_rs;
            mdu_in2    = e_rt;
            cnt_next   = is_div ? DIV_CNT : MUL_CNT;
            state_next = is_div ? ST_DIV : ST_MUL;
          end else if (is_mt_hi) begin
            mdu_hiwe = 1'b1;
            mdu_in1  = e_rs;
          end else if (is_mt_lo) begin
            mdu_lowe = 1'b1;
            mdu_in1  = e_rs;
          end
        end
        default: begin
          // Anything HI/LO-related in E here means the stall was bypassed;
          // it is dropped and recorded as a protocol error.
          guard_hit = is_md;
          cnt_next  = cnt - 4'd1;
          if (cnt == 4'd1)
            state_next = ST_IDLE;
        end
      endcase
    end
  end

`ifdef MDU_DIVZERO_TRAP_EN
  assign div_zero = !reset && (state == ST_IDLE) && dz_trap;
`endif

  assign pending = (state != ST_IDLE);
  assign stall   = d_is_md && (pending || mdu_start);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl
// Directed testbench for mdu_issue_ctrl. A small MDU model drives mdu_busy
// for 5 (multiply) or 10 (divide) cycles after each start pulse.
module tb_mdu_issue_ctrl;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULTU = 4'd1;
  localparam logic [3:0] MULT  = 4'd2;
  localparam logic [3:0] DIVU  = 4'd3;
  localparam logic [3:0] DIV   = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_rs, e_rt;
  logic        d_is_md;
  logic        mdu_busy;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic        mdu_hiwe, mdu_lowe;
  logic [31:0] mdu_in1, mdu_in2;
  logic        stall, pending, err;
`ifdef MDU_DIVZERO_TRAP_EN
  logic        div_zero;
`endif

  int errors = 0;
  int checks = 0;
  int busy_cnt;

  mdu_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .d_is_md   (d_is_md),
    .mdu_busy  (mdu_busy),
    .mdu_start (mdu_start),
    .mdu_op    (mdu_op),
    .mdu_hiwe  (mdu_hiwe),
    .mdu_lowe  (mdu_lowe),
    .mdu_in1   (mdu_in1),
    .mdu_in2   (mdu_in2),
`ifdef MDU_DIVZERO_TRAP_EN
    .div_zero  (div_zero),
`endif
    .stall     (stall),
    .pending   (pending),
    .err       (err)
  );

  always #5 clk = ~clk;

  // MDU stand-in: busy for the op's latency after the start pulse.
  always @(posedge clk) begin
    if (reset)
      busy_cnt <= 0;
    else if (mdu_start)
      busy_cnt <= mdu_op[1] ? 10 : 5;
    else if (busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;
  end
  assign mdu_busy = (busy_cnt != 0);

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic dmd);
    e_valid = v;
    e_op    = op;
    e_rs    = rs;
    e_rt    = rt;
    d_is_md = dmd;
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int stall_n;
    int pend_n;

    reset = 1'b1;
    applyStimulus(1'b0, NONE, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_start",   {31'd0, mdu_start}, 32'd0);
    checkOutput("rst_op",      {29'd0, mdu_op}, 32'd0);
    checkOutput("rst_strobes", {30'd0, mdu_hiwe, mdu_lowe}, 32'd0);
    checkOutput("rst_in1",     mdu_in1, 32'd0);
    checkOutput("rst_in2",     mdu_in2, 32'd0);
    checkOutput("rst_flags",   {29'd0, stall, pending, err}, 32'd0);

    // MULT -2 * 3 with a HI/LO consumer held in D
    tick();
    applyStimulus(1'b1, MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    checkOutput("mult_start", {31'd0, mdu_start}, 32'd1);
    checkOutput("mult_op",    {29'd0, mdu_op}, 32'd1);
    checkOutput("mult_in1",   mdu_in1, 32'hFFFF_FFFE);
    checkOutput("mult_in2",   mdu_in2, 32'd3);
    stall_n = 0;
    pend_n  = 0;
    for (int i = 0; i < 9; i++) begin
      if (stall)   stall_n++;
      if (pending) pend_n++;
      tick();
      applyStimulus(1'b0, NONE, 32'd0, 32'd0, 1'b1);
      if (mdu_start) stall_n = stall_n + 100;
    end
    checkOutput("mult_stall_cycles", stall_n, 32'd6);
    checkOutput("mult_pend_cycles",  pend_n, 32'd5);
    checkOutput("mult_err",          {31'd0, err}, 32'd0);

    // DIVU 100 / 7, then MFHI waiting in D
    applyStimulus(1'b1, DIVU, 32'd100, 32'd7, 1'b1);
    checkOutput("divu_op", {29'd0, mdu_op}, 32'd2);
    stall_n = 0;
    pend_n  = 0;
    for (int i = 0; i < 11; i++) begin
      if (stall)   stall_n++;
      if (pending) pend_n++;
      tick();
      applyStimulus(1'b0, NONE, 32'd0, 32'd0, 1'b1);
    end
    checkOutput("divu_stall_cycles", stall_n, 32'd11);
    checkOutput("divu_pend_cycles",  pend_n, 32'd10);
    checkOutput("divu_after", {30'd0, stall, pending}, 32'd0);
    applyStimulus(1'b1, MFHI, 32'd0, 32'd0, 1'b0);
    checkOutput("mfhi_nodrive", {29'd0, mdu_start, mdu_hiwe, mdu_lowe}, 32'd0);
    checkOutput("mfhi_in1", mdu_in1, 32'd0);

    // MTLO / MTHI strobes
    tick();
    applyStimulus(1'b1, MTLO, 32'h1234, 32'h5555, 1'b1);
    checkOutput("mtlo_strobes", {29'd0, mdu_start, mdu_hiwe, mdu_lowe}, 32'd1);
    checkOutput("mtlo_in1",   mdu_in1, 32'h1234);
    checkOutput("mtlo_in2",   mdu_in2, 32'd0);
    checkOutput("mtlo_stall", {30'd0, stall, pending}, 32'd0);
    tick();
    checkOutput("mtlo_next_pend", {31'd0, pending}, 32'd0);
    applyStimulus(1'b1, MTHI, 32'hCAFE, 32'd0, 1'b0);
    checkOutput("mthi_strobes", {29'd0, mdu_start, mdu_hiwe, mdu_lowe}, 32'd2);
    checkOutput("mthi_in1", mdu_in1, 32'hCAFE);

    // Out-of-range op behaves as NONE
    tick();
    applyStimulus(1'b1, 4'd9, 32'd1, 32'd2, 1'b1);
    checkOutput("op9_quiet", {29'd0, mdu_start, mdu_hiwe, mdu_lowe}, 32'd0);
    checkOutput("op9_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("op9_pend", {31'd0, pending}, 32'd0);

    // MULTU forced into E while a MULT is pending
    applyStimulus(1'b1, MULT, 32'd4, 32'd5, 1'b0);
    tick();
    applyStimulus(1'b1, MULTU, 32'd6, 32'd7, 1'b0);
    checkOutput("guard_start", {31'd0, mdu_start}, 32'd0);
    checkOutput("guard_in1",   mdu_in1, 32'd0);
    tick();
    applyStimulus(1'b0, NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("guard_err", {31'd0, err}, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("guard_err_sticky", {31'd0, err}, 32'd1);
    doReset();
    checkOutput("guard_err_clear", {31'd0, err}, 32'd0);

    // Reset in the middle of a DIV (cnt = 4)
    tick();
    applyStimulus(1'b1, DIV, 32'd50, 32'd5, 1'b0);
    checkOutput("div_op", {29'd0, mdu_op}, 32'd3);
    for (int i = 0; i < 7; i++) begin
      tick();
      applyStimulus(1'b0, NONE, 32'd0, 32'd0, 1'b1);
    end
    checkOutput("div_mid_pend", {31'd0, pending}, 32'd1);
    doReset();
    checkOutput("div_rst_flags", {29'd0, stall, pending, err}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("div_rst_err_quiet", {31'd0, err}, 32'd0);

    // DIV by zero
    applyStimulus(1'b1, DIV, 32'd9, 32'd0, 1'b0);
`ifdef MDU_DIVZERO_TRAP_EN
    checkOutput("dz_pulse", {30'd0, div_zero, mdu_start}, 32'd2);
    tick();
    applyStimulus(1'b0, NONE, 32'd0, 32'd0, 1'b0);
    checkOutput("dz_pulse_end", {30'd0, div_zero, pending}, 32'd0);
`else
    checkOutput("dz_start", {31'd0, mdu_start}, 32'd1);
    pend_n = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      applyStimulus(1'b0, NONE, 32'd0, 32'd0, 1'b0);
      if (pending) pend_n++;
    end
    checkOutput("dz_pend_cycles", pend_n, 32'd10);
`endif
    tick();
    checkOutput("final_err", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
